// File: rtl/dac_mux_pkg.sv
// Shared types and constants for the DAC comparator / sound-source selector.
// Gain is a 0..16 scale applied as (value * g) >> 4.
package dac_mux_pkg;

  typedef enum logic [1:0] {
    SRC_DAC  = 2'd0,
    SRC_CASS = 2'd1,
    SRC_CART = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2
  } fade_st_e;

  localparam int GAIN_MAX = 16;
  localparam int GAIN_W   = 5;
  localparam int GAIN_SH  = 4;
  localparam int SND_W    = 12;

  function automatic logic [SND_W-1:0] apply_gain(input logic [SND_W-1:0] v,
                                                  input logic [GAIN_W-1:0] g);
    logic [SND_W+GAIN_W-1:0] p;
    p = {{GAIN_W{1'b0}}, v} * {{SND_W{1'b0}}, g};
    return SND_W'(p >> GAIN_SH);
  endfunction

endpackage

// File: rtl/dac_mux_snd_fader.sv
// Click-suppression fader: ramps gain to 0, swaps source, ramps back to 16; one gain step per FADE_DIV ce pulses.
// sound is registered (1 clock from src value or gain); no backpressure, target is re-read live every clock.
module snd_fader
  import dac_mux_pkg::*;
#(
  parameter int FADE_DIV = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_ce,
  input  src_e             i_target,
  input  logic [SND_W-1:0] i_src_val,
  output src_e             o_committed,
  output logic [SND_W-1:0] o_sound
);

  localparam int              PW       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(FADE_DIV - 1);
  localparam logic [GAIN_W-1:0] G_MAX  = GAIN_W'(GAIN_MAX);

  fade_st_e          r_state;
  fade_st_e          w_state_nxt;
  logic [GAIN_W-1:0] r_gain;
  logic [GAIN_W-1:0] w_gain_nxt;
  src_e              r_committed;
  src_e              w_committed_nxt;
  logic [PW-1:0]     r_pre;
  logic              w_tick;
  logic [SND_W-1:0]  r_sound;

  assign w_tick = i_ce && (r_pre == PRE_LAST);

  // Prescaler parks at 0 in IDLE so every fade starts on a fresh FADE_DIV boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (r_state == ST_IDLE) begin
      r_pre <= '0;
    end else if (i_ce) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gain_nxt      = r_gain;
    w_committed_nxt = r_committed;
    case (r_state)
      ST_IDLE: begin
        if (i_target != r_committed) w_state_nxt = ST_FADE_OUT;
      end
      ST_FADE_OUT: begin
        if (i_target == r_committed) begin
          w_state_nxt = ST_FADE_IN;
        end else if (w_tick) begin
          if (r_gain != '0) begin
            w_gain_nxt = r_gain - 1'b1;
          end else begin
            w_committed_nxt = i_target;
            w_state_nxt     = ST_FADE_IN;
          end
        end
      end
      ST_FADE_IN: begin
        if (i_target != r_committed) begin
          w_state_nxt = ST_FADE_OUT;
        end else if (w_tick) begin
          if (r_gain < G_MAX) w_gain_nxt = r_gain + 1'b1;
          else                w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_gain      <= '0;
      r_committed <= SRC_NONE;
      r_sound     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gain      <= w_gain_nxt;
      r_committed <= w_committed_nxt;
      r_sound     <= apply_gain(i_src_val, r_gain);
    end
  end

  assign o_committed = r_committed;
  assign o_sound     = r_sound;

endmodule

// File: rtl/dac_mux.sv
// DAC vs joystick-axis comparator with settle model, plus faded sound-source selector; hilo/sound 1-clock registered.
// No backpressure. Define DAC_MUX_HYST_EN for 1-LSB comparator hysteresis (equality holds hilo).
module dac_mux
  import dac_mux_pkg::*;
#(
  parameter int DAC_W      = 6,
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int FADE_DIV   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic [NUM_CH*8-1:0]       axis,
  input  logic [DAC_W-1:0]          dac,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  input  logic                      snden,
  input  logic [SND_W-1:0]          cass_snd,
  input  logic [SND_W-1:0]          cart_snd,
  output logic                      hilo,
  output logic                      hilo_valid,
  output logic [SND_W-1:0]          sound
);

  localparam int                SEL_W    = $clog2(NUM_CH);
  localparam int                CNT_W    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC);

  logic [SEL_W-1:0] r_sel_q;
  logic [DAC_W-1:0] r_dac_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_hilo;
  logic             r_hilo_valid;
  logic [7:0]       w_axis_sel;
  logic [DAC_W-1:0] w_operand;
  logic             w_change;
  logic             w_settled;
  logic             w_hilo_cmp;
  src_e             w_target;
  src_e             w_committed;
  logic [SND_W-1:0] w_src_val;

  assign w_axis_sel = axis[{sel, 3'b000} +: 8];
  assign w_operand  = DAC_W'(w_axis_sel >> (8 - DAC_W));
  assign w_change   = (sel != r_sel_q) || (dac != r_dac_q);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_change)                 w_cnt_nxt = CNT_LOAD;
    else if (ce && r_cnt != '0)   w_cnt_nxt = r_cnt - 1'b1;
  end

  // A change landing on the final settle clock reloads, so it suppresses the update.
  assign w_settled = (w_cnt_nxt == '0);

`ifdef DAC_MUX_HYST_EN
  always_comb begin
    w_hilo_cmp = r_hilo;
    if (w_operand > dac)      w_hilo_cmp = 1'b1;
    else if (w_operand < dac) w_hilo_cmp = 1'b0;
  end
`else
  assign w_hilo_cmp = (w_operand > dac);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_q      <= '0;
      r_dac_q      <= '0;
      r_cnt        <= CNT_LOAD;
      r_hilo       <= 1'b0;
      r_hilo_valid <= 1'b0;
    end else begin
      r_sel_q      <= sel;
      r_dac_q      <= dac;
      r_cnt        <= w_cnt_nxt;
      r_hilo_valid <= w_settled;
      if (w_settled) r_hilo <= w_hilo_cmp;
    end
  end

  assign w_target = snden ? src_e'(sel[1:0]) : SRC_NONE;

  always_comb begin
    w_src_val = '0;
    case (w_committed)
      SRC_DAC:  w_src_val = {dac, {(SND_W - DAC_W){1'b0}}};
      SRC_CASS: w_src_val = cass_snd;
      SRC_CART: w_src_val = cart_snd;
      default:  w_src_val = '0;
    endcase
  end

  snd_fader #(
    .FADE_DIV (FADE_DIV)
  ) u_fader (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_ce        (ce),
    .i_target    (w_target),
    .i_src_val   (w_src_val),
    .o_committed (w_committed),
    .o_sound     (sound)
  );

  assign hilo       = r_hilo;
  assign hilo_valid = r_hilo_valid;

endmodule

// File: doc/dac_mux.md
# dac_mux

Parametrised successor to the CoCo DAC/selector block: compares a DAC_W-bit DAC code against NUM_CH joystick axes, with an analogue-settling model and a validity flag. Routes one of four sound sources (DAC, cassette, cartridge, none) to a 12-bit output. Source changes pass through a click-suppression fade-out/fade-in sequencer. Sits between the PIA outputs (DAC, select lines, sound enable) and the audio mixer / PIA comparator input.

## Interface
- DAC_W, 6: DAC code width; legal 1..8.
- NUM_CH, 4: joystick axis count; power of two, ≥4.
- SETTLE_CYC, 8: ce ticks the comparator needs after any sel/dac change; 0 legal.
- FADE_DIV, 1: ce ticks per fade gain step; ≥1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable for settle and fade timing.
- axis  in  NUM_CH*8  unsigned 8-bit axis positions; channel i at [8i+7:8i].
- dac  in  DAC_W  DAC code.
- sel  in  $clog2(NUM_CH)  axis select; sel[1:0] is also the sound source select.
- snden  in  1  sound enable.
- cass_snd  in  12  cassette audio.
- cart_snd  in  12  cartridge audio.
- hilo  out  1  comparator result; 1 = axis above DAC.
- hilo_valid  out  1  comparator settled.
- sound  out  12  faded audio.

## Operation
- Comparator operand: axis[sel][7 -: DAC_W], unsigned. Default rule: hilo <= (operand > dac).
- Settle counter: loaded with SETTLE_CYC on reset and whenever sel or dac differs from its value on the previous clock. Decrements on ce while nonzero.
- hilo updates only on clocks where the counter is 0; otherwise it holds. hilo_valid = (counter == 0), registered.
- Target source = snden ? sel[1:0] : NONE. Values: DAC → {dac, zero pad to 12}, CASS → cass_snd, CART → cart_snd, NONE → 0.
- Gain g: 0..16. sound <= (src_value * g) >> 4, computed at 17 bits and truncated to 12. Committed source value is sampled live every clock.
- FSM states: IDLE, FADE_OUT, FADE_IN. A tick is a ce pulse that completes FADE_DIV ce counts.
  - IDLE: if target ≠ committed, go to FADE_OUT.
  - FADE_OUT, per tick: if g > 0, decrement g. If g == 0, commit target and go to FADE_IN.
  - FADE_OUT, target reverts to committed: go to FADE_IN from the current g.
  - FADE_IN, per tick: if g < 16, increment g; if g == 16, go to IDLE.
  - FADE_IN, target ≠ committed: go to FADE_OUT from the current g. The target is re-read live, so the last request wins.

## Timing
- Reset values: hilo 0, hilo_valid 0, sound 0, g 0, committed NONE, state IDLE, counter SETTLE_CYC, prescaler 0.
- SETTLE_CYC = 0: hilo follows inputs with 1-clock latency; hilo_valid is 1 from the first clock after reset release.
- A sel/dac change clears hilo_valid on the next clock.
- A change arriving on the same clock as the counter reaching 0 reloads the counter; the change wins and hilo does not update.
- sound latency: 1 clock from src_value or g.
- Full source switch with ce=1, FADE_DIV=1, starting at g=16:
  - 16 ticks of FADE_OUT down to g=0;
  - 1 commit tick;
  - 16 ticks up to g=16;
  - 1 tick to IDLE.
- Reset asserted mid-fade: all state returns to reset values immediately.

## Configuration
- DAC_MUX_HYST_EN defined: the comparator uses 1-LSB hysteresis.
  - hilo sets when operand > dac.
  - hilo clears only when operand < dac.
  - operand == dac holds the previous hilo.
- DAC_MUX_HYST_EN undefined: the plain > rule applies, and equality gives 0.

## Structure
- Package dac_mux_pkg holds:
  - source enum: SRC_DAC=0, SRC_CASS=1, SRC_CART=2, SRC_NONE=3;
  - GAIN_MAX=16 and GAIN_W=5;
  - the sound width constant, 12.
- Sub-module snd_fader holds the FSM, gain register, prescaler and multiply. dac_mux keeps the comparator, settle counter and source mux.

## Test plan
- Comparator: DAC_W=6, SETTLE_CYC=0, axis0=0x80, sel=0, dac=31 → hilo=1 next clock; dac=32 → hilo=0 (with DAC_MUX_HYST_EN: hilo holds 1 at 32, clears at 33).
- Settle: SETTLE_CYC=8, ce=1, change dac → hilo_valid=0 for 8 clocks and hilo frozen. Change dac again at clock 4 → valid returns 8 clocks after that second change.
- Fade: snden=1, steady on DAC with dac=63 (sound=0xFC0); switch sel to 1 with cass_snd=0x800 → sound falls to 0 over 16 ticks, then rises to 0x800 in 16 ticks.
- Revert: start a switch DAC→CART; at g=10 restore sel=0 → FSM ramps back to 16 on DAC without ever reaching g=0.
- Disable: snden 1→0 mid-IDLE → fade to 0, commit NONE, sound stays 0. With FADE_DIV=3, each gain step spans 3 ce pulses.
- Reset: assert reset_n=0 during FADE_IN → all outputs 0 immediately. After release, hilo_valid rises after SETTLE_CYC ce ticks.
